// File: rtl/activation_loader.sv
// Write-side loader for the double-buffered activation buffer.
// Fills one tile into the write bank, then swaps once the read bank is free.
module activation_loader #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W:0]   tile_words,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              buf_write_enable,
    output logic [ADDR_W-1:0] buf_write_addr,
    output logic [DATA_W-1:0] buf_write_data,
    output logic              buf_swap_banks,
    input  logic              consumer_done,
    output logic              tile_ready,
    output logic              busy,
    output logic              cfg_error,
    output logic [15:0]       tiles_loaded
);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        DRAIN,
        WAIT_CONS,
        SWAP
    } state_t;

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_t          state;
    state_t          state_nx;
    logic [ADDR_W:0] tile_len;
    logic [ADDR_W:0] cnt;
    logic            read_bank_full;
    logic            done_pending;

    logic xfer;
    logic last_xfer;
    logic bank_free;
    logic cfg_ok;
    logic accept;

    assign xfer      = (state == FILL) && s_valid;
    assign last_xfer = xfer && (cnt == tile_len - 1'b1);
    assign bank_free = !read_bank_full || done_pending;
    assign cfg_ok    = (tile_words != '0) && (tile_words <= DEPTH);
    assign accept    = (state == IDLE) && start && cfg_ok;

    assign s_ready        = (state == FILL);
    assign busy           = (state != IDLE);
    assign buf_swap_banks = (state == SWAP);

    // Next-state decode for the tile load sequence.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:      if (accept) state_nx = FILL;
            FILL:      if (last_xfer) state_nx = DRAIN;
            DRAIN:     state_nx = bank_free ? SWAP : WAIT_CONS;
            WAIT_CONS: if (bank_free || consumer_done) state_nx = SWAP;
            SWAP:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Tile length latch, word counter and registered write port.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tile_len         <= '0;
            cnt              <= '0;
            buf_write_enable <= 1'b0;
            buf_write_addr   <= '0;
            buf_write_data   <= '0;
        end else begin
            buf_write_enable <= xfer;
            if (accept) begin
                tile_len <= tile_words;
                cnt      <= '0;
            end
            if (xfer) begin
                buf_write_addr <= cnt[ADDR_W-1:0];
                buf_write_data <= s_data;
                cnt            <= cnt + 1'b1;
            end
        end
    end

    // Bank ownership tracking, status flags and tile counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            read_bank_full <= 1'b0;
            done_pending   <= 1'b0;
            cfg_error      <= 1'b0;
            tile_ready     <= 1'b0;
            tiles_loaded   <= '0;
        end else begin
            tile_ready <= (state == SWAP);
            if (state == SWAP) begin
                read_bank_full <= 1'b1;
                done_pending   <= 1'b0;
                tiles_loaded   <= tiles_loaded + 16'd1;
            end else if (consumer_done && read_bank_full) begin
                done_pending   <= 1'b1;
                read_bank_full <= 1'b0;
            end
            if ((state == IDLE) && start) cfg_error <= !cfg_ok;
        end
    end

endmodule

// File: tb/tb_activation_loader.sv
// Scoreboard bench for activation_loader.
// Stimulus queues expected writes/swaps; a monitor checks them.
module tb_activation_loader;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [13:0] tile_words = '0;
    logic        s_valid = 1'b0;
    logic [63:0] s_data = '0;
    logic        s_ready;
    logic        buf_write_enable;
    logic [12:0] buf_write_addr;
    logic [63:0] buf_write_data;
    logic        buf_swap_banks;
    logic        consumer_done = 1'b0;
    logic        tile_ready;
    logic        busy;
    logic        cfg_error;
    logic [15:0] tiles_loaded;

    activation_loader dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .start            (start),
        .tile_words       (tile_words),
        .s_valid          (s_valid),
        .s_data           (s_data),
        .s_ready          (s_ready),
        .buf_write_enable (buf_write_enable),
        .buf_write_addr   (buf_write_addr),
        .buf_write_data   (buf_write_data),
        .buf_swap_banks   (buf_swap_banks),
        .consumer_done    (consumer_done),
        .tile_ready       (tile_ready),
        .busy             (busy),
        .cfg_error        (cfg_error),
        .tiles_loaded     (tiles_loaded)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [12:0] addr;
        logic [63:0] data;
        int          cyc;
    } wr_t;

    wr_t wq[$];
    int  sq[$];

    int tests = 0;
    int fails = 0;
    int last_swap = -10;
    int last_xfer = 0;
    logic [12:0] exp_addr = '0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pop expected writes/swaps as the DUT presents them.
    always @(negedge clock) begin
        if (reset_n) begin
            if (tile_ready || (cyc == last_swap + 1))
                check("tile_ready", tile_ready, cyc == last_swap + 1);
            if (buf_write_enable) begin
                if (wq.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    check("wr_addr", buf_write_addr, e.addr);
                    check("wr_data", buf_write_data, e.data);
                    check("wr_cycle", cyc, e.cyc);
                end
            end
            if (buf_swap_banks) begin
                check("swap_with_write", buf_write_enable, 0);
                if (sq.size() == 0) begin
                    check("unexpected_swap", 1, 0);
                end else begin
                    int ec;
                    ec = sq.pop_front();
                    check("swap_cycle", cyc, ec);
                end
                last_swap = cyc;
            end
        end
    end

    task automatic do_start(input logic [13:0] tw);
        start = 1'b1;
        tile_words = tw;
        exp_addr = '0;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [63:0] d);
        int g = 0;
        s_valid = 1'b1;
        s_data = d;
        while (!s_ready && g < 100) begin
            @(negedge clock);
            g++;
        end
        if (!s_ready) begin
            check("s_ready_timeout", 0, 1);
        end else begin
            wq.push_back('{exp_addr, d, cyc + 1});
            exp_addr++;
            last_xfer = cyc;
        end
        @(negedge clock);
        s_valid = 1'b0;
        consumer_done = 1'b0;
    endtask

    task automatic pulse_done();
        consumer_done = 1'b1;
        @(negedge clock);
        consumer_done = 1'b0;
    endtask

    task automatic wait_idle(input logic [15:0] exp_tiles);
        int g = 0;
        while (busy && g < 50) begin
            @(negedge clock);
            g++;
        end
        check("idle_timeout", busy, 0);
        @(negedge clock);
        check("wq_drained", wq.size(), 0);
        check("sq_drained", sq.size(), 0);
        check("tiles_loaded", tiles_loaded, exp_tiles);
    endtask

    logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        int s;
        int m;
        int k;

        repeat (2) @(negedge clock);
        check("rst_s_ready", s_ready, 0);
        check("rst_we", buf_write_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_tiles", tiles_loaded, 0);
        reset_n = 1'b1;
        @(negedge clock);

        // Basic tile, free bank.
        s = cyc;
        do_start(14'd4);
        check("fill_s_ready", s_ready, 1);
        for (int i = 0; i < 4; i++) send_word(64'hA0 + 64'(i));
        check("basic_last_xfer", last_xfer, s + 4);
        sq.push_back(last_xfer + 2);
        @(negedge clock);
        @(negedge clock);
        check("basic_busy_n3", busy, 0);
        check("basic_tr_n3", tile_ready, 1);
        wait_idle(16'd1);

        // Consumer gating: bank full, hold in WAIT_CONS.
        do_start(14'd2);
        send_word(64'hB0);
        send_word(64'hB1);
        repeat (10) @(negedge clock);
        check("gate_busy", busy, 1);
        check("gate_s_ready", s_ready, 0);
        check("gate_swap", buf_swap_banks, 0);
        m = cyc;
        sq.push_back(m + 1);
        pulse_done();
        wait_idle(16'd2);

        // consumer_done during FILL: no wait after DRAIN.
        do_start(14'd3);
        send_word(64'hC0);
        consumer_done = 1'b1;
        send_word(64'hC1);
        send_word(64'hC2);
        sq.push_back(last_xfer + 2);
        wait_idle(16'd3);

        // Backpressure with s_valid gaps.
        pulse_done();
        do_start(14'd3);
        k = 0;
        for (int i = 0; i < 6; i++) begin
            s_valid = pat[i];
            s_data = 64'hD0 + 64'(k);
            if (pat[i]) begin
                check("bp_s_ready", s_ready, 1);
                wq.push_back('{exp_addr, s_data, cyc + 1});
                exp_addr++;
                last_xfer = cyc;
                k++;
            end
            @(negedge clock);
        end
        s_valid = 1'b0;
        sq.push_back(last_xfer + 2);
        wait_idle(16'd4);

        // Illegal configurations.
        do_start(14'd0);
        check("cfg0_err", cfg_error, 1);
        check("cfg0_busy", busy, 0);
        check("cfg0_s_ready", s_ready, 0);
        do_start(14'd8193);
        check("cfg8193_err", cfg_error, 1);
        check("cfg8193_busy", busy, 0);
        check("cfg8193_s_ready", s_ready, 0);
        pulse_done();
        do_start(14'd1);
        check("cfg_cleared", cfg_error, 0);
        send_word(64'hE0);
        sq.push_back(last_xfer + 2);
        wait_idle(16'd5);

        // Full depth tile.
        pulse_done();
        do_start(14'd8192);
        for (int i = 0; i < 8192; i++)
            send_word(64'hF00D_0000_0000_0000 | 64'(i));
        sq.push_back(last_xfer + 2);
        wait_idle(16'd6);

        // Reset mid-fill.
        do_start(14'd8);
        for (int i = 0; i < 5; i++) send_word(64'h5A00 + 64'(i));
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("mrst_s_ready", s_ready, 0);
        check("mrst_we", buf_write_enable, 0);
        check("mrst_addr", buf_write_addr, 0);
        check("mrst_data", buf_write_data, 0);
        check("mrst_swap", buf_swap_banks, 0);
        check("mrst_tr", tile_ready, 0);
        check("mrst_busy", busy, 0);
        check("mrst_cfg", cfg_error, 0);
        check("mrst_tiles", tiles_loaded, 0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        do_start(14'd2);
        send_word(64'h77);
        send_word(64'h78);
        sq.push_back(last_xfer + 2);
        wait_idle(16'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
